cc_alu_seq: RTL and testbench

Parametrised, registered successor to the datapath's combinational ALU. Operands and opcode are latched on a start handshake. Single-cycle logic and arithmetic ops finish in one clock. Shifts and multiply run iteratively. Result and active-low condition flags are registered and held until the next accepted operation. The block sits between the register-file read buses and the datapath write-back mux; the control unit drives it with start/done handshaking.

---
 rtl/cc_alu_seq_pkg.sv | 37 +++
 rtl/cc_alu_seqmul.sv | 36 +++
 rtl/cc_alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_cc_alu_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_alu_seq_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions for the sequential ALU.
package cc_alu_seq_pkg;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_NOTA  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_INC   = 4'b1010;
  localparam logic [3:0] OP_DEC   = 4'b1011;
  localparam logic [3:0] OP_MULL  = 4'b1100;
  localparam logic [3:0] OP_MULH  = 4'b1101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic isShift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic isMul(input logic [3:0] op);
    return (op == OP_MULL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/cc_alu_seqmul.sv
// Iterative unsigned shift-add multiplier; load performs the first iteration.
module cc_alu_seqmul #(
  parameter int DATAWIDTH_BUS = 32
) (
  input  logic                         clock,
  input  logic                         load,
  input  logic                         step,
  input  logic [DATAWIDTH_BUS-1:0]     multiplicand,
  input  logic [DATAWIDTH_BUS-1:0]     multiplier,
  output logic [2*DATAWIDTH_BUS-1:0]   productNext
);

  localparam int W = DATAWIDTH_BUS;

  logic [W-1:0]   mcandReg;
  logic [2*W-1:0] productReg;

  // Upper half accumulates, lower half holds the unconsumed multiplier bits.
  function automatic logic [2*W-1:0] mulStep(input logic [2*W-1:0] p, input logic [W-1:0] m);
    logic [W:0] acc;
    acc = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
    return {acc, p[W-1:1]};
  endfunction

  assign productNext = mulStep(productReg, mcandReg);

  always_ff @(posedge clock) begin
    if (load) begin
      mcandReg   <= multiplicand;
      productReg <= mulStep({{W{1'b0}}, multiplier}, multiplicand);
    end else if (step) begin
      productReg <= productNext;
    end
  end

endmodule

// File: rtl/cc_alu_seq.sv
// Registered ALU with start/done handshake; shifts and multiply iterate one bit per clock.
module cc_alu_seq
  import cc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic                               CC_ALU_SEQ_CLOCK_50,
  input  logic                               CC_ALU_SEQ_RESET_InHigh,
  input  logic                               CC_ALU_SEQ_start_InHigh,
  input  logic                               CC_ALU_SEQ_setCode_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_SEQ_selection_InBus,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataA_InBus,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_dataB_InBus,
  output logic                               CC_ALU_SEQ_busy_OutHigh,
  output logic                               CC_ALU_SEQ_done_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_data_OutBus,
  output logic                               CC_ALU_SEQ_zero_OutLow,
  output logic                               CC_ALU_SEQ_negative_OutLow,
  output logic                               CC_ALU_SEQ_carry_OutLow,
  output logic                               CC_ALU_SEQ_overflow_OutLow
);

  localparam int W               = DATAWIDTH_BUS;
  localparam int DATAWIDTH_SHAMT = $clog2(DATAWIDTH_BUS);

  logic                               clk;
  logic                               rst;
  logic                               start;
  logic [DATAWIDTH_ALU_SELECTION-1:0] sel;
  logic [W-1:0]                       dataA;
  logic [W-1:0]                       dataB;

  assign clk   = CC_ALU_SEQ_CLOCK_50;
  assign rst   = CC_ALU_SEQ_RESET_InHigh;
  assign start = CC_ALU_SEQ_start_InHigh;
  assign sel   = CC_ALU_SEQ_selection_InBus;
  assign dataA = CC_ALU_SEQ_dataA_InBus;
  assign dataB = CC_ALU_SEQ_dataB_InBus;

  stateT                              state;
  logic                               busyReg;
  logic                               doneReg;
  logic [W-1:0]                       dataReg;
  logic [3:0]                         flagsLow;
  logic [DATAWIDTH_SHAMT-1:0]         cnt;
  logic [DATAWIDTH_ALU_SELECTION-1:0] opReg;
  logic                               setCodeReg;
  logic [W-1:0]                       shReg;

  // Returns {bit shifted out, shifted value} for a single-bit step.
  function automatic logic [W:0] shiftOne(input logic [3:0] op, input logic [W-1:0] x);
    case (op)
      OP_SLL:  return {x[W-1], x[W-2:0], 1'b0};
      OP_SRL:  return {x[0], 1'b0, x[W-1:1]};
      default: return {x[0], x[W-1], x[W-1:1]};
    endcase
  endfunction

  function automatic logic [3:0] packFlagsLow(input logic [W-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f[FLAG_Z] = ~(r == {W{1'b0}});
    f[FLAG_N] = ~r[W-1];
    f[FLAG_C] = ~c;
    f[FLAG_V] = ~v;
    return f;
  endfunction

  // Acceptance-cycle path: single-cycle ops plus the first shift step.
  logic [DATAWIDTH_SHAMT-1:0] shamtIn;
  logic [W-1:0]               arithB;
  logic [W:0]                 immShift;
  logic [W:0]                 arithSum;
  logic [W-1:0]               immRes;
  logic                       immC;
  logic                       immV;
  logic                       needsIter;

  assign shamtIn   = dataB[DATAWIDTH_SHAMT-1:0];
  assign arithB    = ((sel == OP_INC) || (sel == OP_DEC)) ? W'(1) : dataB;
  assign immShift  = shiftOne(sel, dataA);
  assign needsIter = isMul(sel) || (isShift(sel) && (shamtIn > DATAWIDTH_SHAMT'(1)));

  always_comb begin
    immRes   = dataA;
    immC     = 1'b0;
    immV     = 1'b0;
    arithSum = '0;
    case (sel)
      OP_OR:   immRes = dataA | dataB;
      OP_AND:  immRes = dataA & dataB;
      OP_NOTA: immRes = ~dataA;
      OP_XOR:  immRes = dataA ^ dataB;
      OP_SLL, OP_SRL, OP_SRA: begin
        if (shamtIn != '0) begin
          immRes = immShift[W-1:0];
          immC   = immShift[W];
        end
      end
      OP_ADD, OP_INC: begin
        arithSum = {1'b0, dataA} + {1'b0, arithB};
        immRes   = arithSum[W-1:0];
        immC     = arithSum[W];
        immV     = (dataA[W-1] == arithB[W-1]) && (arithSum[W-1] != dataA[W-1]);
      end
      OP_SUB, OP_DEC: begin
        arithSum = {1'b0, dataA} - {1'b0, arithB};
        immRes   = arithSum[W-1:0];
        immC     = arithSum[W];
        immV     = (dataA[W-1] != arithB[W-1]) && (arithSum[W-1] != dataA[W-1]);
      end
      default: ;
    endcase
  end

  // Iteration path: shifter register or multiplier, selected by the latched opcode.
  logic [W:0]     busyShift;
  logic [2*W-1:0] prodNext;
  logic           busyIsMul;
  logic           mulHigh;
  logic [W-1:0]   busyRes;
  logic           busyC;
  logic           busyV;

  assign busyShift = shiftOne(opReg, shReg);
  assign busyIsMul = isMul(opReg);
  assign mulHigh   = |prodNext[2*W-1:W];
  assign busyRes   = !busyIsMul ? busyShift[W-1:0] :
                     (opReg == OP_MULH) ? prodNext[2*W-1:W] : prodNext[W-1:0];
  assign busyC     = busyIsMul ? mulHigh : busyShift[W];
  assign busyV     = busyIsMul & mulHigh;

  cc_alu_seqmul #(
    .DATAWIDTH_BUS(W)
  ) uMul (
    .clock        (clk),
    .load         ((state == IDLE) && start && isMul(sel)),
    .step         ((state == BUSY) && busyIsMul),
    .multiplicand (dataA),
    .multiplier   (dataB),
    .productNext  (prodNext)
  );

  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      opReg      <= sel;
      setCodeReg <= CC_ALU_SEQ_setCode_InHigh;
      shReg      <= immShift[W-1:0];
    end else if (state == BUSY) begin
      shReg <= busyShift[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      dataReg  <= '0;
      flagsLow <= 4'b1111;
      cnt      <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (needsIter) begin
              state   <= BUSY;
              busyReg <= 1'b1;
              cnt     <= isMul(sel) ? DATAWIDTH_SHAMT'(W - 2) : shamtIn - DATAWIDTH_SHAMT'(2);
            end else begin
              doneReg <= 1'b1;
              dataReg <= immRes;
              if (CC_ALU_SEQ_setCode_InHigh) flagsLow <= packFlagsLow(immRes, immC, immV);
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state   <= IDLE;
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            dataReg <= busyRes;
            if (setCodeReg) flagsLow <= packFlagsLow(busyRes, busyC, busyV);
          end else begin
            cnt <= cnt - DATAWIDTH_SHAMT'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CC_ALU_SEQ_busy_OutHigh    = busyReg;
  assign CC_ALU_SEQ_done_OutHigh    = doneReg;
  assign CC_ALU_SEQ_data_OutBus     = dataReg;
  assign CC_ALU_SEQ_zero_OutLow     = flagsLow[FLAG_Z];
  assign CC_ALU_SEQ_negative_OutLow = flagsLow[FLAG_N];
  assign CC_ALU_SEQ_carry_OutLow    = flagsLow[FLAG_C];
  assign CC_ALU_SEQ_overflow_OutLow = flagsLow[FLAG_V];

endmodule

// File: tb/tb_cc_alu_seq.sv
// Bench for cc_alu_seq at W=8: vector table, handshake corner cases, randomized model check.
module tb_cc_alu_seq;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       setCode;
  logic [3:0] sel;
  logic [7:0] dA;
  logic [7:0] dB;
  logic       busyO;
  logic       doneO;
  logic [7:0] dataO;
  logic       zN, nN, cN, vN;

  int checks = 0;
  int errors = 0;

  cc_alu_seq #(
    .DATAWIDTH_BUS(W),
    .DATAWIDTH_ALU_SELECTION(4)
  ) dut (
    .CC_ALU_SEQ_CLOCK_50        (clk),
    .CC_ALU_SEQ_RESET_InHigh    (rst),
    .CC_ALU_SEQ_start_InHigh    (start),
    .CC_ALU_SEQ_setCode_InHigh  (setCode),
    .CC_ALU_SEQ_selection_InBus (sel),
    .CC_ALU_SEQ_dataA_InBus     (dA),
    .CC_ALU_SEQ_dataB_InBus     (dB),
    .CC_ALU_SEQ_busy_OutHigh    (busyO),
    .CC_ALU_SEQ_done_OutHigh    (doneO),
    .CC_ALU_SEQ_data_OutBus     (dataO),
    .CC_ALU_SEQ_zero_OutLow     (zN),
    .CC_ALU_SEQ_negative_OutLow (nN),
    .CC_ALU_SEQ_carry_OutLow    (cN),
    .CC_ALU_SEQ_overflow_OutLow (vN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expD;
    logic [3:0] expF;   // {zero, negative, carry, overflow} active-low
    int         expLat;
  } vecT;

  typedef struct {
    logic [7:0] d;
    logic [3:0] fLow;
    int         lat;
  } modelT;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] flagsNow();
    return {zN, nN, cN, vN};
  endfunction

  // Reference behaviour written from the opcode definitions using plain integer arithmetic.
  function automatic modelT model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    modelT m;
    int s, full, sa, sb, bb, sres;
    logic [7:0] r;
    logic c, v;
    s = int'(b[2:0]);
    c = 1'b0;
    v = 1'b0;
    m.lat = 1;
    r = a;
    case (op)
      4'd1: r = a | b;
      4'd2: r = a & b;
      4'd3: r = ~a;
      4'd4: r = a ^ b;
      4'd5: begin r = 8'(a << s); c = (s != 0) ? a[8 - s] : 1'b0; m.lat = (s > 1) ? s : 1; end
      4'd6: begin r = a >> s; c = (s != 0) ? a[s - 1] : 1'b0; m.lat = (s > 1) ? s : 1; end
      4'd7: begin r = 8'($signed(a) >>> s); c = (s != 0) ? a[s - 1] : 1'b0; m.lat = (s > 1) ? s : 1; end
      4'd8, 4'd10: begin
        bb = (op == 4'd8) ? int'(b) : 1;
        full = int'(a) + bb;
        r = full[7:0];
        c = full > 255;
        sa = int'($signed(a));
        sb = (op == 4'd8) ? int'($signed(b)) : 1;
        sres = sa + sb;
        v = (sres > 127) || (sres < -128);
      end
      4'd9, 4'd11: begin
        bb = (op == 4'd9) ? int'(b) : 1;
        full = int'(a) - bb;
        r = full[7:0];
        c = int'(a) < bb;
        sa = int'($signed(a));
        sb = (op == 4'd9) ? int'($signed(b)) : 1;
        sres = sa - sb;
        v = (sres > 127) || (sres < -128);
      end
      4'd12, 4'd13: begin
        full = int'(a) * int'(b);
        r = (op == 4'd12) ? full[7:0] : full[15:8];
        c = full > 255;
        v = c;
        m.lat = 8;
      end
      default: r = a;
    endcase
    m.d = r;
    m.fLow = {~(r == 8'h00), ~r[7], ~c, ~v};
    return m;
  endfunction

  // Start an operation, scramble inputs afterwards, wait (bounded) for done.
  task automatic runOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic sc,
                       output int lat, output logic busyOk);
    sel = op; dA = a; dB = b; setCode = sc; start = 1'b1;
    tick();
    start = 1'b0;
    sel = 4'($urandom); dA = 8'($urandom); dB = 8'($urandom); setCode = 1'($urandom);
    lat = 0;
    busyOk = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (doneO) begin
        lat = i;
        break;
      end
      if (!busyO) busyOk = 1'b0;
      tick();
    end
    if (doneO && busyO) busyOk = 1'b0;
  endtask

  vecT        vecs[14];
  int         lat;
  logic       busyOk;
  logic [3:0] expFlags;
  modelT      m;
  int         doneCount;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h8, 8'h7F, 8'h01, 8'h80, 4'b1010, 1};
    vecs[1]  = '{4'h9, 8'h00, 8'h01, 8'hFF, 4'b1001, 1};
    vecs[2]  = '{4'h5, 8'hA1, 8'h03, 8'h08, 4'b1101, 3};
    vecs[3]  = '{4'h7, 8'h80, 8'h00, 8'h80, 4'b1011, 1};
    vecs[4]  = '{4'hD, 8'hFF, 8'hFF, 8'hFE, 4'b1000, 8};
    vecs[5]  = '{4'hC, 8'hFF, 8'hFF, 8'h01, 4'b1100, 8};
    vecs[6]  = '{4'h6, 8'hF0, 8'h04, 8'h0F, 4'b1111, 4};
    vecs[7]  = '{4'h7, 8'h81, 8'h01, 8'hC0, 4'b1001, 1};
    vecs[8]  = '{4'hB, 8'h00, 8'h55, 8'hFF, 4'b1001, 1};
    vecs[9]  = '{4'h3, 8'hFF, 8'h00, 8'h00, 4'b0111, 1};
    vecs[10] = '{4'hE, 8'h3C, 8'h99, 8'h3C, 4'b1111, 1};
    vecs[11] = '{4'h8, 8'h80, 8'h80, 8'h00, 4'b0100, 1};
    vecs[12] = '{4'h5, 8'h01, 8'h07, 8'h80, 4'b1011, 7};
    vecs[13] = '{4'h7, 8'h80, 8'hFB, 8'hF0, 4'b1011, 3};

    rst = 1'b1; start = 1'b0; setCode = 1'b0; sel = 4'h0; dA = 8'h00; dB = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", busyO, 0);
    check("reset_done", doneO, 0);
    check("reset_data", dataO, 0);
    check("reset_flags", flagsNow(), 4'b1111);

    // Directed vector table
    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat, busyOk);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].expLat);
      check($sformatf("vec%0d_busy", i), busyOk, 1);
      check($sformatf("vec%0d_data", i), dataO, vecs[i].expD);
      check($sformatf("vec%0d_flags", i), flagsNow(), vecs[i].expF);
      tick();
      check($sformatf("vec%0d_donepulse", i), doneO, 0);
      check($sformatf("vec%0d_hold", i), dataO, vecs[i].expD);
    end

    // SUB then INC started in the SUB done cycle
    sel = 4'h9; dA = 8'h00; dB = 8'h01; setCode = 1'b1; start = 1'b1;
    tick();
    check("b2b_sub_done", doneO, 1);
    check("b2b_sub_data", dataO, 8'hFF);
    sel = 4'hA; dA = 8'hFF; dB = 8'h00;
    tick();
    start = 1'b0;
    check("b2b_inc_done", doneO, 1);
    check("b2b_inc_data", dataO, 8'h00);
    check("b2b_inc_flags", flagsNow(), 4'b0101);

    // Flags hold with setCode=0
    runOp(4'h9, 8'h00, 8'h01, 1'b1, lat, busyOk);
    check("sub_flags", flagsNow(), 4'b1001);
    runOp(4'h4, 8'h5A, 8'h5A, 1'b0, lat, busyOk);
    check("xor_data", dataO, 8'h00);
    check("xor_flags_held", flagsNow(), 4'b1001);
    tick();

    // Start pulses while busy must be ignored
    sel = 4'hD; dA = 8'hFF; dB = 8'hFF; setCode = 1'b1; start = 1'b1;
    tick();
    sel = 4'h0; dA = 8'h11; dB = 8'h22;
    doneCount = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 7) start = 1'b0;
      if (doneO) begin
        doneCount++;
        check("ignore_lat", i, 8);
        check("ignore_data", dataO, 8'hFE);
      end
      tick();
    end
    check("ignore_donecount", doneCount, 1);

    // Reset in the middle of a multiply
    sel = 4'hC; dA = 8'hFF; dB = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busyO, 0);
    check("abort_done", doneO, 0);
    check("abort_data", dataO, 0);
    check("abort_flags", flagsNow(), 4'b1111);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (doneO) doneCount++;
      tick();
    end
    check("abort_nodone", doneCount, 0);

    // Randomized operations against the reference model
    expFlags = 4'b1111;
    for (int k = 0; k < 80; k++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic       sc;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      sc = 1'($urandom);
      m = model(op, a, b);
      if (sc) expFlags = m.fLow;
      runOp(op, a, b, sc, lat, busyOk);
      check($sformatf("rnd%0d_op%0h_lat", k, op), lat, m.lat);
      check($sformatf("rnd%0d_op%0h_busy", k, op), busyOk, 1);
      check($sformatf("rnd%0d_op%0h_data", k, op), dataO, m.d);
      check($sformatf("rnd%0d_op%0h_flags", k, op), flagsNow(), expFlags);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check($sformatf("rnd%0d_idle_done", k), doneO, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
